// File: rtl/sdram_pattern_tester.sv
// SDRAM pattern exerciser: streams a generated pattern through the Avalon-MM write master,
// reads it back through the read master and compares. Optional LFSR pattern: SDRAM_TESTER_LFSR_EN.
module sdram_pattern_tester #(
    parameter int ADDRESSWIDTH = 28,
    parameter int DATAWIDTH    = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [ADDRESSWIDTH-1:0] base_addr,
    input  logic [15:0]             num_words,
    input  logic [DATAWIDTH-1:0]    seed,
    output logic                    ctl_wr_fixed_location,
    output logic [ADDRESSWIDTH-1:0] ctl_wr_write_base,
    output logic [ADDRESSWIDTH-1:0] ctl_wr_write_length,
    output logic                    ctl_wr_go,
    input  logic                    ctl_wr_done,
    output logic                    usr_wr_write_buffer,
    output logic [DATAWIDTH-1:0]    usr_wr_buffer_data,
    input  logic                    usr_wr_buffer_full,
    output logic                    ctl_rd_fixed_location,
    output logic [ADDRESSWIDTH-1:0] ctl_rd_read_base,
    output logic [ADDRESSWIDTH-1:0] ctl_rd_read_length,
    output logic                    ctl_rd_go,
    input  logic                    ctl_rd_done,
    output logic                    usr_rd_read_buffer,
    input  logic [DATAWIDTH-1:0]    usr_rd_buffer_data,
    input  logic                    usr_rd_data_available,
    output logic                    busy,
    output logic                    pass,
    output logic                    fail,
    output logic [15:0]             err_count,
    output logic [ADDRESSWIDTH-1:0] first_err_addr
);

    localparam int AW = ADDRESSWIDTH;
    localparam int DW = DATAWIDTH;
    localparam logic [DW-1:0] ONE_W = {{(DW-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WR_GO    = 3'd1,
        ST_WR_FILL  = 3'd2,
        ST_WR_WAIT  = 3'd3,
        ST_RD_GO    = 3'd4,
        ST_RD_DRAIN = 3'd5,
        ST_DONE     = 3'd6
    } state_t;

    state_t          state_r;
    state_t          state_next_s;
    logic [15:0]     idx_r;
    logic [15:0]     num_words_r;
    logic [DW-1:0]   seed_r;
    logic [DW-1:0]   pattern_r;
    logic            wr_done_r;
    logic            rd_done_r;
    logic            start_ok_s;
    logic            push_s;
    logic            pop_s;
    logic            mismatch_s;

    function automatic logic [DW-1:0] pattern_first(input logic [DW-1:0] s);
`ifdef SDRAM_TESTER_LFSR_EN
        pattern_first = (s == {DW{1'b0}}) ? ONE_W : s;
`else
        pattern_first = s;
`endif
    endfunction

    function automatic logic [DW-1:0] pattern_next(input logic [DW-1:0] p);
`ifdef SDRAM_TESTER_LFSR_EN
        pattern_next = (p >> 1) ^ (p[0] ? DW'(32'h8020_0003) : {DW{1'b0}});
`else
        pattern_next = p + ONE_W;
`endif
    endfunction

    assign ctl_wr_fixed_location = 1'b0;
    assign ctl_rd_fixed_location = 1'b0;
    assign ctl_rd_read_base      = ctl_wr_write_base;
    assign ctl_rd_read_length    = ctl_wr_write_length;
    assign usr_wr_buffer_data    = pattern_r;

    // FIFO handshakes must respond in the same cycle as the full/available flags
    assign start_ok_s = start && ((state_r == ST_IDLE) || (state_r == ST_DONE));
    assign push_s     = (state_r == ST_WR_FILL) && !usr_wr_buffer_full && (idx_r < num_words_r);
    assign pop_s      = (state_r == ST_RD_DRAIN) && usr_rd_data_available && (idx_r < num_words_r);
    assign mismatch_s = pop_s && (usr_rd_buffer_data != pattern_r);
    assign usr_wr_write_buffer = push_s;
    assign usr_rd_read_buffer  = pop_s;

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_next_s = (num_words == 16'd0) ? ST_DONE : ST_WR_GO;
                end else begin
                    state_next_s = state_r;
                end
            end
            ST_WR_GO:   state_next_s = ST_WR_FILL;
            ST_WR_FILL: begin
                if (push_s && (idx_r == (num_words_r - 16'd1))) begin
                    state_next_s = ST_WR_WAIT;
                end else begin
                    state_next_s = ST_WR_FILL;
                end
            end
            ST_WR_WAIT: begin
                if (wr_done_r || ctl_wr_done) begin
                    state_next_s = ST_RD_GO;
                end else begin
                    state_next_s = ST_WR_WAIT;
                end
            end
            ST_RD_GO:   state_next_s = ST_RD_DRAIN;
            ST_RD_DRAIN: begin
                if ((idx_r == num_words_r) && (rd_done_r || ctl_rd_done)) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_RD_DRAIN;
                end
            end
            default:    state_next_s = ST_IDLE;
        endcase
    end

    // Datapath, done latches and registered status outputs
    always_ff @(posedge clk) begin
        if (!reset) begin
            idx_r               <= 16'd0;
            num_words_r         <= 16'd0;
            seed_r              <= {DW{1'b0}};
            pattern_r           <= {DW{1'b0}};
            wr_done_r           <= 1'b0;
            rd_done_r           <= 1'b0;
            ctl_wr_write_base   <= {AW{1'b0}};
            ctl_wr_write_length <= {AW{1'b0}};
            ctl_wr_go           <= 1'b0;
            ctl_rd_go           <= 1'b0;
            busy                <= 1'b0;
            pass                <= 1'b0;
            fail                <= 1'b0;
            err_count           <= 16'd0;
            first_err_addr      <= {AW{1'b0}};
        end else begin
            ctl_wr_go <= (state_next_s == ST_WR_GO);
            ctl_rd_go <= (state_next_s == ST_RD_GO);
            busy      <= (state_next_s != ST_IDLE) && (state_next_s != ST_DONE);
            if (start_ok_s) begin
                idx_r               <= 16'd0;
                num_words_r         <= num_words;
                seed_r              <= seed;
                pattern_r           <= pattern_first(seed);
                wr_done_r           <= 1'b0;
                rd_done_r           <= 1'b0;
                ctl_wr_write_base   <= {base_addr[AW-1:2], 2'b00};
                ctl_wr_write_length <= AW'({num_words, 2'b00});
                pass                <= (num_words == 16'd0);
                fail                <= 1'b0;
                err_count           <= 16'd0;
                first_err_addr      <= {AW{1'b0}};
            end else begin
                case (state_r)
                    ST_WR_FILL: begin
                        if (ctl_wr_done) wr_done_r <= 1'b1;
                        if (push_s) begin
                            idx_r     <= idx_r + 16'd1;
                            pattern_r <= pattern_next(pattern_r);
                        end
                    end
                    ST_WR_WAIT: begin
                        if (ctl_wr_done) wr_done_r <= 1'b1;
                        if (state_next_s == ST_RD_GO) idx_r <= 16'd0;
                    end
                    ST_RD_GO: begin
                        pattern_r <= pattern_first(seed_r);
                    end
                    ST_RD_DRAIN: begin
                        if (ctl_rd_done) rd_done_r <= 1'b1;
                        if (pop_s) begin
                            idx_r     <= idx_r + 16'd1;
                            pattern_r <= pattern_next(pattern_r);
                        end
                        if (mismatch_s) begin
                            if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
                            if (err_count == 16'd0) begin
                                first_err_addr <= ctl_wr_write_base + AW'({idx_r, 2'b00});
                            end
                        end
                        // Final count is stable here: the exit needs idx==num_words from an earlier pop
                        if (state_next_s == ST_DONE) begin
                            pass <= (err_count == 16'd0);
                            fail <= (err_count != 16'd0);
                        end
                    end
                    default: begin
                        idx_r <= idx_r;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sdram_pattern_tester.sv
// Directed bench for sdram_pattern_tester (default incrementing pattern) with a small
// write/read master and memory model driven from the stimulus task.
module tb_sdram_pattern_tester;

    logic        clk = 1'b0;
    logic        reset, start;
    logic [27:0] base_addr;
    logic [15:0] num_words;
    logic [31:0] seed;
    logic        ctl_wr_fixed_location, ctl_wr_go, ctl_wr_done;
    logic [27:0] ctl_wr_write_base, ctl_wr_write_length;
    logic        usr_wr_write_buffer, usr_wr_buffer_full;
    logic [31:0] usr_wr_buffer_data;
    logic        ctl_rd_fixed_location, ctl_rd_go, ctl_rd_done;
    logic [27:0] ctl_rd_read_base, ctl_rd_read_length;
    logic        usr_rd_read_buffer, usr_rd_data_available;
    logic [31:0] usr_rd_buffer_data;
    logic        busy, pass, fail;
    logic [15:0] err_count;
    logic [27:0] first_err_addr;

    int checks = 0;
    int failures = 0;

    logic [31:0] mem [0:63];
    int  wr_cnt, rd_ptr, n_model, corrupt_idx, rel, full_lo, full_hi;
    int  wr_go_cnt, rd_go_cnt, push_full_cnt;
    bit  wr_active, rd_loaded, rd_done_sent;

    sdram_pattern_tester dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
        .num_words(num_words), .seed(seed),
        .ctl_wr_fixed_location(ctl_wr_fixed_location), .ctl_wr_write_base(ctl_wr_write_base),
        .ctl_wr_write_length(ctl_wr_write_length), .ctl_wr_go(ctl_wr_go), .ctl_wr_done(ctl_wr_done),
        .usr_wr_write_buffer(usr_wr_write_buffer), .usr_wr_buffer_data(usr_wr_buffer_data),
        .usr_wr_buffer_full(usr_wr_buffer_full),
        .ctl_rd_fixed_location(ctl_rd_fixed_location), .ctl_rd_read_base(ctl_rd_read_base),
        .ctl_rd_read_length(ctl_rd_read_length), .ctl_rd_go(ctl_rd_go), .ctl_rd_done(ctl_rd_done),
        .usr_rd_read_buffer(usr_rd_read_buffer), .usr_rd_buffer_data(usr_rd_buffer_data),
        .usr_rd_data_available(usr_rd_data_available),
        .busy(busy), .pass(pass), .fail(fail), .err_count(err_count), .first_err_addr(first_err_addr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: observe DUT handshakes at negedge, then update the master/memory model after posedge
    task automatic tick();
        @(negedge clk);
        if (ctl_wr_go) begin wr_go_cnt++; wr_active = 1'b1; end
        if (usr_wr_write_buffer) begin
            if (usr_wr_buffer_full) push_full_cnt++;
            if (wr_cnt < 64) mem[wr_cnt] = usr_wr_buffer_data;
            wr_cnt++;
        end
        if (ctl_rd_go) begin rd_go_cnt++; rd_loaded = 1'b1; rd_ptr = 0; rd_done_sent = 1'b0; end
        if (usr_rd_read_buffer) rd_ptr++;
        @(posedge clk);
        #1;
        rel++;
        usr_wr_buffer_full = (rel >= full_lo) && (rel <= full_hi);
        ctl_wr_done = 1'b0;
        if (wr_active && wr_cnt == n_model) begin ctl_wr_done = 1'b1; wr_active = 1'b0; end
        usr_rd_data_available = rd_loaded && (rd_ptr < n_model);
        usr_rd_buffer_data = (rd_ptr < 64) ? (mem[rd_ptr] ^ ((rd_ptr == corrupt_idx) ? 32'h1 : 32'h0)) : 32'h0;
        // Read master reports done early, before the FIFO is drained
        ctl_rd_done = 1'b0;
        if (rd_loaded && !rd_done_sent) begin ctl_rd_done = 1'b1; rd_done_sent = 1'b1; end
    endtask

    task automatic start_test(input logic [27:0] b, input int n, input logic [31:0] s, input int cidx);
        base_addr = b; num_words = 16'(n); seed = s;
        n_model = n; corrupt_idx = cidx;
        wr_cnt = 0; rd_ptr = 0; rel = 0; wr_go_cnt = 0; rd_go_cnt = 0; push_full_cnt = 0;
        wr_active = 1'b0; rd_loaded = 1'b0; rd_done_sent = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic run_until_done(input string tag);
        for (int i = 0; i < 300 && !(pass || fail); i++) tick();
        check({tag, "_done_timeout"}, 64'(pass | fail), 64'd1);
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; base_addr = 28'h0; num_words = 16'd0; seed = 32'h0;
        ctl_wr_done = 1'b0; usr_wr_buffer_full = 1'b0; ctl_rd_done = 1'b0;
        usr_rd_buffer_data = 32'h0; usr_rd_data_available = 1'b0;
        n_model = 0; corrupt_idx = -1; rel = 0; full_lo = 1000; full_hi = 0;
        wr_cnt = 0; rd_ptr = 0; wr_go_cnt = 0; rd_go_cnt = 0; push_full_cnt = 0;
        wr_active = 1'b0; rd_loaded = 1'b0; rd_done_sent = 1'b0;
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;

        // Reset held low for three cycles
        repeat (3) tick();
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_outputs_zero", 64'(|{ctl_wr_fixed_location, ctl_wr_write_base, ctl_wr_write_length,
              ctl_wr_go, usr_wr_write_buffer, usr_wr_buffer_data, ctl_rd_fixed_location,
              ctl_rd_read_base, ctl_rd_read_length, ctl_rd_go, usr_rd_read_buffer,
              busy, pass, fail, err_count, first_err_addr}), 64'd0);
        reset = 1'b1;
        tick();

        // Ideal memory: base 0x100, 4 words from seed 0x10
        start_test(28'h100, 4, 32'h10, -1);
        check("a_busy", 64'(busy), 64'd1);
        check("a_wr_go", 64'(ctl_wr_go), 64'd1);
        check("a_wr_base", 64'(ctl_wr_write_base), 64'h100);
        check("a_wr_len", 64'(ctl_wr_write_length), 64'h10);
        run_until_done("a");
        check("a_pass", 64'({pass, fail}), 64'b10);
        check("a_err", 64'(err_count), 64'd0);
        check("a_first_err", 64'(first_err_addr), 64'd0);
        check("a_busy_done", 64'(busy), 64'd0);
        check("a_go_counts", 64'({wr_go_cnt[7:0], rd_go_cnt[7:0]}), 64'h0101);
        check("a_pushes", 64'(wr_cnt), 64'd4);
        check("a_rd_base_len", 64'({ctl_rd_read_base, ctl_rd_read_length}), {8'h0, 28'h100, 28'h10});
        check("a_mem", {mem[0][15:0], mem[1][15:0], mem[2][15:0], mem[3][15:0]}, 64'h0010_0011_0012_0013);

        // Same run with word 2 corrupted on read-back
        start_test(28'h100, 4, 32'h10, 2);
        check("b_cleared", 64'({pass, fail, err_count}), 64'd0);
        run_until_done("b");
        check("b_fail", 64'({pass, fail}), 64'b01);
        check("b_err", 64'(err_count), 64'd1);
        check("b_first_err", 64'(first_err_addr), 64'h108);

        // 8 words, write FIFO full for cycles 2-5, pattern wraps, unaligned base, stray start mid-write
        full_lo = 2; full_hi = 5;
        start_test(28'h203, 8, 32'hFFFF_FFFE, -1);
        check("c_base_len", 64'({ctl_wr_write_base, ctl_wr_write_length}), {8'h0, 28'h200, 28'h20});
        repeat (6) tick();
        check("c_pushes_after_full", 64'(wr_cnt), 64'd1);
        start = 1'b1; num_words = 16'd3; seed = 32'h0;
        tick();
        start = 1'b0;
        run_until_done("c");
        full_lo = 1000; full_hi = 0;
        check("c_pass", 64'({pass, fail}), 64'b10);
        check("c_push_while_full", 64'(push_full_cnt), 64'd0);
        check("c_pushes", 64'(wr_cnt), 64'd8);
        check("c_wr_go_count", 64'(wr_go_cnt), 64'd1);
        check("c_mem_wrap", {mem[1], mem[2]}, 64'hFFFF_FFFF_0000_0000);
        check("c_mem_last", 64'(mem[7]), 64'h5);

        // Zero-length test goes straight to DONE
        start_test(28'h40, 0, 32'h77, -1);
        check("d_pass_next_cycle", 64'({pass, fail, busy}), 64'b100);
        check("d_no_wr_go", 64'(ctl_wr_go), 64'd0);
        repeat (4) tick();
        check("d_go_counts", 64'(wr_go_cnt + rd_go_cnt), 64'd0);
        check("d_len", 64'(ctl_wr_write_length), 64'd0);

        // Reset during read drain
        start_test(28'h100, 4, 32'h10, -1);
        for (int i = 0; i < 100 && rd_go_cnt == 0; i++) tick();
        check("e_rd_go_seen", 64'(rd_go_cnt), 64'd1);
        repeat (2) tick();
        check("e_in_drain", 64'({busy, usr_rd_read_buffer}), 64'b11);
        reset = 1'b0;
        wr_active = 1'b0; rd_loaded = 1'b0; rd_done_sent = 1'b1;
        tick();
        check("e_rst_busy", 64'(busy), 64'd0);
        check("e_rst_outputs_zero", 64'(|{ctl_wr_write_base, ctl_wr_write_length, ctl_wr_go,
              usr_wr_write_buffer, usr_wr_buffer_data, ctl_rd_go, usr_rd_read_buffer,
              pass, fail, err_count, first_err_addr}), 64'd0);
        reset = 1'b1;
        tick();
        check("e_idle_after_rst", 64'({busy, pass, fail}), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
